audio_sd2_dac: RTL and testbench
================================

Name: audio_sd2_dac

Overview:
- Single-channel 2nd-order delta-sigma DAC stage that consumes the volume-scaled signed samples from the audio output pipeline and produces a 1-bit pulse-density output.
- Adds a click-free soft enable/disable gain ramp and saturating integrators with a sticky clip flag.
- Instantiated once per stereo channel, directly downstream of the volume/mute pipeline.

Parameters:
- WIDTH, 16, sample width (signed two's complement)
- ACC_W, 20, integrator width (signed); must be ≥ WIDTH+3
- RAMP_LOG2, 4, gain ramp step period is 2^RAMP_LOG2 clocks per gain LSB

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (reset when 0, sampled on clk rising edge)
- in_data  in  WIDTH  signed sample
- in_valid  in  1  in_data valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- en  in  1  level: 1 = run/ramp up, 0 = ramp down/stop
- clr_clip  in  1  one-cycle pulse, clears stat_clip
- pdm  out  1  modulator bit
- pdm_oe  out  1  output enable for pad
- busy  out  1  state != ST_OFF
- stat_clip  out  1  sticky: an integrator saturated

Behaviour:
- Reset (rst==0): state=ST_OFF, gain=0, sample=0, x_eff=0, i1=i2=0, ramp counter=0, pdm=0, pdm_oe=0, busy=0, stat_clip=0, in_ready=0. Reset asserted mid-ramp or mid-run takes effect on the next edge, with no ramp-down.
- in_ready = (state != ST_OFF). On accept, the sample register loads in_data. The held sample persists until the next accept; no underrun handling.
- FSM:
  - ST_OFF -> ST_UP when en=1.
  - ST_UP: gain += 1 every 2^RAMP_LOG2 clocks. Goes to ST_ON when gain reaches 256. Goes to ST_DOWN when en=0, keeping the current gain.
  - ST_ON -> ST_DOWN when en=0.
  - ST_DOWN: gain -= 1 on the same cadence. Goes to ST_UP when en=1, keeping the current gain. When gain reaches 0 it goes to ST_OFF, and i1, i2, the sample register and pdm clear that cycle.
- Ramp counter resets to 0 on every state change.
- Gain is 9-bit unsigned, range 0..256. Registered x_eff = (sample * gain) >>> 8, arithmetic shift, truncated to WIDTH. Gain 256 is identity.
- Modulator updates every clock when state != ST_OFF:
  - FS = 2^(WIDTH-1), sign-extended to ACC_W.
  - y = ~i2[ACC_W-1] (i.e. 1 when i2 ≥ 0).
  - fb = y ? +FS : -FS.
  - i1_n = sat(i1 + x_eff - fb).
  - i2_n = sat(i2 + i1_n - fb).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets stat_clip when a clamp occurs.
  - pdm <= y.
- Latency: sample accepted at edge N -> x_eff at N+1 -> i1/i2 at N+2 -> first affected pdm at N+3.
- pdm_oe = busy, registered alongside pdm.
- stat_clip: a set event wins over clr_clip in the same cycle. stat_clip is not cleared by ST_OFF.
- Duty for steady input x at gain 256 converges to (x+FS)/(2·FS). For |x| ≤ 0.75·FS the loop is stable with no clipping at ACC_W=20.

Decomposition:
- Shared package audio_pkg:
  - state encodings ST_OFF=0, ST_UP=1, ST_ON=2, ST_DOWN=3 (2-bit)
  - GAIN_W=9, GAIN_UNITY=256
  - saturate function (signed, width-generic)
- One natural sub-module, audio_sd2_core: the x_eff → integrator → pdm loop, with inputs x_eff, run, flush and outputs pdm, clip_evt.
- The top level holds the FSM, ramp counter, gain multiply and handshake.

Test Plan:
- Reset: rst=0 for 3 clocks with en=1, in_valid=1 -> pdm=0, pdm_oe=0, busy=0, in_ready=0, stat_clip=0 throughout.
- Ramp timing (RAMP_LOG2=2): en 0->1 at edge T -> busy=1 at T+1; ST_ON reached at T+1+1024 (±1). Then en=0 -> busy returns to 0 after 1024 (±1) more clocks; i1=i2=0 afterwards.
- Density (gain 256, ST_ON): x=0 -> ones count in 4096 clocks is 2048±2; x=0x4000 -> 3072±4; x=0xC000 -> 1024±4; stat_clip stays 0.
- Ramp abort: en=1 for 200 clocks (gain 50 at RAMP_LOG2=2), then en=0 for 40 clocks (gain 40), then en=1 -> ST_ON reached 864±1 clocks later; no busy drop.
- Clip: x=0x7FFF sustained in ST_ON -> stat_clip=1 within 2000 clocks. A clr_clip pulse while clipping persists -> stat_clip stays 1. With x=0 and after ST_OFF, clr_clip -> 0.
- Reset mid-run: rst=0 for one cycle during ST_ON with x=0x4000 -> next cycle state ST_OFF, pdm=0, pdm_oe=0, gain=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output DAC stages.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    localparam int              GAIN_W     = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    // Clamp a wide signed value into the range of a w-bit signed integer.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/audio_sd2_core.sv
// Second-order delta-sigma loop: x_eff -> two saturating integrators -> 1-bit pdm.
module audio_sd2_core
    import audio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x_eff,
    input  logic                    run,
    input  logic                    flush,
    output logic                    pdm,
    output logic                    clip_evt
);

    localparam logic signed [ACC_W-1:0] FS = ACC_W'(1 << (WIDTH - 1));

    logic signed [ACC_W-1:0] i1;
    logic signed [ACC_W-1:0] i2;
    logic signed [ACC_W-1:0] fb;
    logic signed [ACC_W-1:0] i1_n;
    logic signed [ACC_W-1:0] i2_n;
    logic signed [63:0]      sum1;
    logic signed [63:0]      sum2;
    logic signed [63:0]      sat1;
    logic signed [63:0]      sat2;
    logic                    y;

    always_comb begin
        y        = ~i2[ACC_W-1];
        fb       = y ? FS : -FS;
        sum1     = 64'(i1) + 64'(x_eff) - 64'(fb);
        sat1     = saturate(sum1, ACC_W);
        i1_n     = sat1[ACC_W-1:0];
        sum2     = 64'(i2) + 64'(i1_n) - 64'(fb);
        sat2     = saturate(sum2, ACC_W);
        i2_n     = sat2[ACC_W-1:0];
        clip_evt = run && !flush && ((sat1 != sum1) || (sat2 != sum2));
    end

    // Integrator / output register stage
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
        end else if (run) begin
            i1  <= i1_n;
            i2  <= i2_n;
            pdm <= y;
        end
    end

endmodule

// File: rtl/audio_sd2_dac.sv
// Delta-sigma DAC channel: soft enable gain ramp, sample handshake and gain scaling ahead of the loop.
module audio_sd2_dac
    import audio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_W     = 20,
    parameter int RAMP_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    en,
    input  logic                    clr_clip,
    output logic                    pdm,
    output logic                    pdm_oe,
    output logic                    busy,
    output logic                    stat_clip
);

    state_t                      state;
    state_t                      state_n;
    logic [GAIN_W-1:0]           gain;
    logic [GAIN_W-1:0]           gain_n;
    logic [RAMP_LOG2-1:0]        ramp_cnt;
    logic                        tick;
    logic                        flush;
    logic                        run;
    logic                        clip_evt;
    logic signed [WIDTH-1:0]     sample_p0;
    logic signed [WIDTH-1:0]     x_eff_p1;
    logic signed [WIDTH+GAIN_W:0] prod;

    assign tick     = &ramp_cnt;
    assign run      = (state != ST_OFF);
    assign busy     = run;
    assign in_ready = run;
    assign flush    = (state == ST_DOWN) && (state_n == ST_OFF);
    assign prod     = sample_p0 * $signed({1'b0, gain});

    always_comb begin
        state_n = state;
        gain_n  = gain;
        case (state)
            ST_OFF: begin
                if (en) state_n = ST_UP;
            end
            ST_UP: begin
                if (!en) begin
                    state_n = ST_DOWN;
                end else if (tick) begin
                    gain_n = gain + 1'b1;
                    if (gain_n == GAIN_UNITY) state_n = ST_ON;
                end
            end
            ST_ON: begin
                if (!en) state_n = ST_DOWN;
            end
            ST_DOWN: begin
                // Abort from an UP that never ticked leaves gain at 0
                if (en) begin
                    state_n = ST_UP;
                end else if (gain == '0) begin
                    state_n = ST_OFF;
                end else if (tick) begin
                    gain_n = gain - 1'b1;
                    if (gain_n == '0) state_n = ST_OFF;
                end
            end
            default: state_n = ST_OFF;
        endcase
    end

    // Control, sample (p0) and scaled sample (p1) registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_OFF;
            gain      <= '0;
            ramp_cnt  <= '0;
            pdm_oe    <= 1'b0;
            stat_clip <= 1'b0;
            sample_p0 <= '0;
            x_eff_p1  <= '0;
        end else begin
            state    <= state_n;
            gain     <= gain_n;
            ramp_cnt <= (state_n != state) ? '0 : ramp_cnt + 1'b1;
            pdm_oe   <= (state_n != ST_OFF);
            if (flush)
                sample_p0 <= '0;
            else if (in_valid && in_ready)
                sample_p0 <= in_data;
            x_eff_p1 <= WIDTH'(prod >>> 8);
            if (clip_evt)
                stat_clip <= 1'b1;
            else if (clr_clip)
                stat_clip <= 1'b0;
        end
    end

    audio_sd2_core #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .x_eff    (x_eff_p1),
        .run      (run),
        .flush    (flush),
        .pdm      (pdm),
        .clip_evt (clip_evt)
    );

endmodule

// File: tb/tb_audio_sd2_dac.sv
// Self-checking bench for audio_sd2_dac: reset, ramp timing, density, clipping, ramp abort, mid-run reset.
module tb_audio_sd2_dac;
    import audio_pkg::*;

    localparam int WIDTH     = 16;
    localparam int ACC_W     = 20;
    localparam int RAMP_LOG2 = 2;
    localparam int RAMP_CLKS = 256 * (1 << RAMP_LOG2);

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [WIDTH-1:0] in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    en = 1'b0;
    logic                    clr_clip = 1'b0;
    logic                    pdm;
    logic                    pdm_oe;
    logic                    busy;
    logic                    stat_clip;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int val;
        int tol;
    } exp_t;
    exp_t exp_q[$];

    logic signed [WIDTH-1:0] pats [3] = '{16'sh0000, 16'sh4000, -16'sh4000};
    int                      tols [3] = '{2, 4, 4};

    always #5 clk = ~clk;

    audio_sd2_dac #(
        .WIDTH     (WIDTH),
        .ACC_W     (ACC_W),
        .RAMP_LOG2 (RAMP_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .clr_clip  (clr_clip),
        .pdm       (pdm),
        .pdm_oe    (pdm_oe),
        .busy      (busy),
        .stat_clip (stat_clip)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 16'sh4000; clr_clip = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (pdm !== 1'b0)       begin errors++; $display("FAIL reset_pdm cyc%0d got %b want 0", c, pdm); end
            checks++; if (pdm_oe !== 1'b0)    begin errors++; $display("FAIL reset_pdm_oe cyc%0d got %b want 0", c, pdm_oe); end
            checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy cyc%0d got %b want 0", c, busy); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready cyc%0d got %b want 0", c, in_ready); end
            checks++; if (stat_clip !== 1'b0) begin errors++; $display("FAIL reset_stat_clip cyc%0d got %b want 0", c, stat_clip); end
        end
        rst = 1'b1; en = 1'b0; in_data = '0;
        step();
    endtask

    task automatic test_ramp();
        int   n;
        exp_t e;
        en = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_rise got %b want 1", busy); end
        exp_q.push_back('{RAMP_CLKS, 1});
        n = 0;
        while (dut.state !== ST_ON && n < RAMP_CLKS + 200) begin step(); n++; end
        e = exp_q.pop_front();
        checks++; if (n < e.val - e.tol || n > e.val + e.tol) begin errors++; $display("FAIL ramp_up_time got %0d want %0d+-%0d", n, e.val, e.tol); end
        checks++; if (pdm_oe !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL ramp_on_flags got oe=%b rdy=%b want 1 1", pdm_oe, in_ready); end
        en = 1'b0;
        exp_q.push_back('{RAMP_CLKS, 1});
        n = 0;
        while (busy !== 1'b0 && n < RAMP_CLKS + 200) begin step(); n++; end
        e = exp_q.pop_front();
        checks++; if (n < e.val - e.tol || n > e.val + e.tol) begin errors++; $display("FAIL ramp_down_time got %0d want %0d+-%0d", n, e.val, e.tol); end
        checks++; if (dut.u_core.i1 !== '0 || dut.u_core.i2 !== '0) begin errors++; $display("FAIL ramp_off_integrators got i1=%0d i2=%0d want 0 0", dut.u_core.i1, dut.u_core.i2); end
        checks++; if (pdm !== 1'b0 || pdm_oe !== 1'b0 || dut.gain !== '0) begin errors++; $display("FAIL ramp_off_outputs got pdm=%b oe=%b gain=%0d want 0 0 0", pdm, pdm_oe, dut.gain); end
    endtask

    task automatic test_density();
        int   n;
        int   ones;
        exp_t e;
        en = 1'b1;
        n = 0;
        while (dut.state !== ST_ON && n < RAMP_CLKS + 200) begin step(); n++; end
        checks++; if (dut.state !== ST_ON) begin errors++; $display("FAIL density_reach_on got state=%0d want %0d", dut.state, ST_ON); end
        for (int k = 0; k < 3; k++) begin
            in_data = pats[k];
            repeat (300) step();
            exp_q.push_back('{((int'(pats[k]) + 32768) * 4096) / 65536, tols[k]});
            ones = 0;
            repeat (4096) begin step(); ones += int'(pdm); end
            e = exp_q.pop_front();
            checks++; if (ones < e.val - e.tol || ones > e.val + e.tol) begin errors++; $display("FAIL density_x%0d got %0d ones want %0d+-%0d", k, ones, e.val, e.tol); end
        end
        checks++; if (stat_clip !== 1'b0) begin errors++; $display("FAIL density_no_clip got %b want 0", stat_clip); end
    endtask

    task automatic test_clip();
        int n;
        in_data = 16'sh7FFF;
        n = 0;
        while (stat_clip !== 1'b1 && n < 2000) begin step(); n++; end
        checks++; if (stat_clip !== 1'b1) begin errors++; $display("FAIL clip_set got %b want 1", stat_clip); end
        repeat (5) step();
        clr_clip = 1'b1;
        step();
        clr_clip = 1'b0;
        checks++; if (stat_clip !== 1'b1) begin errors++; $display("FAIL clip_set_wins got %b want 1", stat_clip); end
        in_data = '0;
        en = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < RAMP_CLKS + 400) begin step(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clip_ramp_off got busy=%b want 0", busy); end
        checks++; if (stat_clip !== 1'b1) begin errors++; $display("FAIL clip_sticky_off got %b want 1", stat_clip); end
        clr_clip = 1'b1;
        step();
        clr_clip = 1'b0;
        checks++; if (stat_clip !== 1'b0) begin errors++; $display("FAIL clip_clear got %b want 0", stat_clip); end
    endtask

    task automatic test_abort();
        int   n;
        int   g;
        logic dropped;
        exp_t e;
        in_data = '0;
        dropped = 1'b0;
        en = 1'b1;
        repeat (200) begin step(); if (busy !== 1'b1) dropped = 1'b1; end
        g = int'(dut.gain);
        checks++; if (g < 49 || g > 51) begin errors++; $display("FAIL abort_gain_up got %0d want 50+-1", g); end
        en = 1'b0;
        repeat (40) begin step(); if (busy !== 1'b1) dropped = 1'b1; end
        g = int'(dut.gain);
        checks++; if (g < 39 || g > 41) begin errors++; $display("FAIL abort_gain_down got %0d want 40+-1", g); end
        en = 1'b1;
        exp_q.push_back('{(256 - 40) * (1 << RAMP_LOG2), 1});
        n = 0;
        while (dut.state !== ST_ON && n < RAMP_CLKS + 200) begin
            step(); n++;
            if (busy !== 1'b1) dropped = 1'b1;
        end
        e = exp_q.pop_front();
        checks++; if (n < e.val - e.tol || n > e.val + e.tol) begin errors++; $display("FAIL abort_to_on got %0d want %0d+-%0d", n, e.val, e.tol); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL abort_busy_drop got %b want 0", dropped); end
    endtask

    task automatic test_reset_mid();
        in_data = 16'sh4000;
        repeat (100) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        en = 1'b0;
        checks++; if (dut.state !== ST_OFF) begin errors++; $display("FAIL midrst_state got %0d want %0d", dut.state, ST_OFF); end
        checks++; if (pdm !== 1'b0 || pdm_oe !== 1'b0) begin errors++; $display("FAIL midrst_pdm got pdm=%b oe=%b want 0 0", pdm, pdm_oe); end
        checks++; if (dut.gain !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_gain got gain=%0d busy=%b want 0 0", dut.gain, busy); end
        checks++; if (dut.u_core.i1 !== '0 || dut.u_core.i2 !== '0) begin errors++; $display("FAIL midrst_integrators got i1=%0d i2=%0d want 0 0", dut.u_core.i1, dut.u_core.i2); end
        repeat (5) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stays_off got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_density();
        test_clip();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
